uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_pkg.sv | 12 +
 rtl/uart_tx_arb_rr_pick.sv | 27 ++
 rtl/uart_tx_arb.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the UART TX FIFO write-port arbiter.
package uart_tx_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_N_SRC     = 4;
    localparam int DEF_MAX_BEATS = 16;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping upward.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    int p;

    always_comb begin
        idx = '0;
        any = 1'b0;
        p   = 0;
        for (int k = 0; k < N; k++) begin
            p = (int'(ptr) + k) % N;
            if (!any && req[p]) begin
                any = 1'b1;
                idx = W'(p);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter merging N byte streams into one UART TX FIFO write port.
import uart_tx_arb_pkg::*;

module uart_tx_arb #(
    parameter int N_SRC     = DEF_N_SRC,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC*8-1:0]       s_tdata,
    input  logic [N_SRC-1:0]         s_tvalid,
    input  logic [N_SRC-1:0]         s_tlast,
    output logic [N_SRC-1:0]         s_tready,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(N_SRC)-1:0] grant_id,
    output logic                     busy,
    output logic                     trunc_err,
    input  logic                     err_clr
);

    localparam int W = $clog2(N_SRC);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   rr_ptr;
    logic [W-1:0]   pick_idx;
    logic [W-1:0]   ptr_nxt;
    logic           pick_any;
    logic [7:0]     beat_cnt;
    logic           xfer;
    logic           last_beat;
    logic           cap_beat;
    logic           release_g;
    logic           trunc_set;

    rr_pick #(.N(N_SRC)) u_pick (
        .req (s_tvalid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign xfer      = m_axis_tvalid & m_axis_tready;
    assign last_beat = s_tlast[grant_id];
    assign cap_beat  = (beat_cnt == 8'(MAX_BEATS - 1));
    assign release_g = xfer & (last_beat | cap_beat);
    assign trunc_set = xfer & cap_beat & ~last_beat;
    assign ptr_nxt   = (grant_id == W'(N_SRC - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (pick_any)  state_nxt = GRANT;
            GRANT: if (release_g) state_nxt = IDLE;
        endcase
    end

    // Outputs are gated by rst so the port goes quiet during reset itself.
    always_comb begin
        busy          = (state == GRANT) & ~rst;
        m_axis_tvalid = 1'b0;
        s_tready      = '0;
        m_axis_tdata  = s_tdata[{grant_id, 3'b000} +: 8];
        if (busy) begin
            m_axis_tvalid      = s_tvalid[grant_id];
            s_tready[grant_id] = m_axis_tready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            trunc_err <= 1'b0;
        end else begin
            if (state == IDLE && pick_any) grant_id <= pick_idx;
            if (release_g) begin
                rr_ptr   <= ptr_nxt;
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            // A truncation in the same cycle as err_clr must stay visible.
            if (trunc_set)    trunc_err <= 1'b1;
            else if (err_clr) trunc_err <= 1'b0;
        end
    end

endmodule
